mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the fetch stage (I side) and the
//  load/store stage (D side). Single outstanding transaction, D-priority with a
//  fetch anti-starvation guard. Drives stall_if/stall_mem into the hazard unit,
//  which holds the affected pipeline stages while a side waits for data.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width; byte-enable width is DW/8
//  STARVE_LIMIT 4   max consecutive D grants while i_req is pending (>=1)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous reset, active-high
//  i_req      in   1     fetch request; held with i_addr until i_valid
//  i_addr     in   AW    fetch address
//  i_valid    out  1     1-cycle pulse: i_rdata valid, fetch complete
//  i_rdata    out  DW    fetch data
//  d_req      in   1     load/store request; held with d_* until d_valid
//  d_we       in   1     1=store, 0=load
//  d_addr     in   AW    data address
//  d_wdata    in   DW    store data
//  d_be       in   DW/8  store byte enables
//  d_valid    out  1     1-cycle pulse: load data valid / store acknowledged
//  d_rdata    out  DW    load data
//  m_req      out  1     memory request; held until m_gnt
//  m_we       out  1     memory write enable
//  m_addr     out  AW    memory address
//  m_wdata    out  DW    memory write data
//  m_be       out  DW/8  memory byte enables (all-ones for fetch)
//  m_gnt      in   1     memory accepted request this cycle
//  m_rvalid   in   1     response (read data or write ack), >=1 cycle after m_gnt
//  m_rdata    in   DW    memory read data
//  stall_if   out  1     = i_req & ~i_valid
//  stall_mem  out  1     = d_req & ~d_valid
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE; owner register (0=I, 1=D).
//  IDLE: if d_req|i_req, pick owner, register m_we/m_addr/m_wdata/m_be, -> ISSUE.
//   Pick: D if d_req, unless i_req & starve_cnt==STARVE_LIMIT -> I; else I.
//   Fetch transaction: m_we=0, m_be all-ones, m_wdata=0.
//  ISSUE: m_req=1, payload registers stable; m_gnt -> WAIT (m_req low next cycle).
//  WAIT: m_req=0; on m_rvalid: owner's *_valid=1 same cycle, *_rdata=m_rdata
//   (combinational pass-through), -> IDLE. One idle cycle between transactions.
//  Latency: request at cycle 0 (IDLE), m_req cycle 1; with m_gnt cycle 1 and
//   m_rvalid cycle 2, *_valid at cycle 2 (3 cycles incl. request cycle).
//  starve_cnt: at a D grant with i_req=1 -> +1 (saturates at STARVE_LIMIT);
//   at any I grant or a D grant with i_req=0 -> 0.
//  m_rvalid in IDLE/ISSUE is ignored (no *_valid). *_rdata=m_rdata always;
//   only meaningful with the matching *_valid.
//  Requester dropping req before its *_valid: transaction completes on memory,
//   *_valid still pulses; no abort.
//  Reset (async, any state): state=IDLE, owner=0, starve_cnt=0; m_req=0, m_we=0,
//   m_addr=0, m_wdata=0, m_be=0, i_valid=0, d_valid=0. In-flight response lost;
//   requester re-arbitrates after reset release.
//  stall_* are combinational; with req low they are 0.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs perf_istall[31:0], perf_dstall[31:0],
//   perf_starve[15:0]; +1 per cycle stall_if / stall_mem high, +1 per forced
//   I grant by starve guard; all wrap modulo width; reset to 0.
//  Not defined: those ports and counters do not exist; behaviour otherwise same.
// TESTING
//  Fetch only, addr 0x100, m_gnt at cycle 1, m_rvalid+rdata 0x00A00093 at cycle 2
//   -> i_valid 1 pulse at cycle 2 with i_rdata 0x00A00093; stall_if 1 in cycles 0-1.
//  i_req and d_req (store 0x2000, data 0xDEADBEEF, be 0xF) same cycle -> D first:
//   m_we=1, m_addr=0x2000; I issued after d_valid + 1 idle cycle.
//  d_req held for 6 back-to-back loads while i_req high, STARVE_LIMIT=4 -> grants
//   D,D,D,D,I,D,D; starve_cnt returns to 0 after I grant.
//  m_gnt held low 5 cycles in ISSUE -> m_req and payload stable all 5 cycles;
//   m_rvalid asserted in ISSUE -> ignored, no *_valid.
//  rst asserted in WAIT (D owner) -> next edge-free check: m_req=0, d_valid=0;
//   later m_rvalid with state IDLE -> no *_valid; new d_req issues normally.
//  ARB_PERF_CNT_EN: scenario 3 -> perf_starve=1, perf_istall equals stall_if
//   cycle count observed by bench.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D).
// Ports: clk/rst; i_* fetch request/response; d_* load/store request/response;
//   m_* memory port (req held until gnt, response on m_rvalid); stall_if/stall_mem
//   to the hazard unit. Optional perf_* counters when ARB_PERF_CNT_EN is defined.
// Latency: request seen in IDLE, m_req next cycle, *_valid in the m_rvalid cycle.
// Backpressure: m_req/payload held in ISSUE until m_gnt; requesters hold until *_valid.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_valid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_valid,
   output logic [DW-1:0]   d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_be,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [DW-1:0]   m_rdata,
   output logic            stall_if,
   output logic            stall_mem
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]     perf_istall,
   output logic [31:0]     perf_dstall,
   output logic [15:0]     perf_starve
`endif
);

   localparam int BW = DW / 8;
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;          // 0 = fetch, 1 = load/store
   logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
   logic            m_we_q, m_we_d;
   logic [AW-1:0]   m_addr_q, m_addr_d;
   logic [DW-1:0]   m_wdata_q, m_wdata_d;
   logic [BW-1:0]   m_be_q, m_be_d;
   logic            force_i;
   logic            rsp_fire;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_be_d       = m_be_q;
      force_i      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (d_req | i_req) begin
               // Fetch wins over a pending D request only once D has taken
               // STARVE_LIMIT consecutive grants while fetch was waiting.
               force_i = d_req & i_req & (starve_cnt_q == LIMIT);
               if (d_req & ~force_i) begin
                  owner_d   = 1'b1;
                  m_we_d    = d_we;
                  m_addr_d  = d_addr;
                  m_wdata_d = d_wdata;
                  m_be_d    = d_be;
                  if (!i_req)
                     starve_cnt_d = '0;
                  else if (starve_cnt_q != LIMIT)
                     starve_cnt_d = starve_cnt_q + CW'(1);
               end else begin
                  owner_d      = 1'b0;
                  m_we_d       = 1'b0;
                  m_addr_d     = i_addr;
                  m_wdata_d    = '0;
                  m_be_d       = '1;
                  starve_cnt_d = '0;
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: if (m_gnt)    state_d = S_WAIT;
         S_WAIT:  if (m_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         starve_cnt_q <= '0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_be_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_be_q       <= m_be_d;
      end
   end

   // Responses outside WAIT belong to no live transaction and are dropped.
   assign rsp_fire  = (state_q == S_WAIT) & m_rvalid;
   assign i_valid   = rsp_fire & ~owner_q;
   assign d_valid   = rsp_fire & owner_q;
   assign i_rdata   = m_rdata;
   assign d_rdata   = m_rdata;
   assign m_req     = (state_q == S_ISSUE);
   assign m_we      = m_we_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign m_be      = m_be_q;
   assign stall_if  = i_req & ~i_valid;
   assign stall_mem = d_req & ~d_valid;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_istall_q, perf_istall_d;
   logic [31:0] perf_dstall_q, perf_dstall_d;
   logic [15:0] perf_starve_q, perf_starve_d;

   always_comb begin
      perf_istall_d = perf_istall_q + {31'd0, stall_if};
      perf_dstall_d = perf_dstall_q + {31'd0, stall_mem};
      perf_starve_d = perf_starve_q + {15'd0, force_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_istall_q <= '0;
         perf_dstall_q <= '0;
         perf_starve_q <= '0;
      end else begin
         perf_istall_q <= perf_istall_d;
         perf_dstall_q <= perf_dstall_d;
         perf_starve_q <= perf_starve_d;
      end
   end

   assign perf_istall = perf_istall_q;
   assign perf_dstall = perf_dstall_q;
   assign perf_starve = perf_starve_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_valid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_valid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        m_req, m_we, m_gnt, m_rvalid;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   logic        stall_if, stall_mem;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_istall, perf_dstall;
   logic [15:0] perf_starve;
`endif

   mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_PERF_CNT_EN
      , .perf_istall(perf_istall), .perf_dstall(perf_dstall), .perf_starve(perf_starve)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        side;   // 0 = fetch, 1 = load/store
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mtx_t;

   mtx_t        mq[$];
   logic [31:0] iq[$];
   logic [31:0] dq[$];

   int vectors     = 0;
   int miscompares = 0;
   int istall_seen = 0;
   int last_dvalid_cyc = 0;
   int last_igrant_cyc = 0;

   int gnt_delay = 0;
   int rsp_delay = 1;
   int spur_cyc  = -1;

   function automatic mtx_t mk(input logic side, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be);
      mtx_t t;
      t.side = side; t.we = we; t.addr = a; t.wdata = wd; t.be = be;
      return t;
   endfunction

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h00A0_0093;
      return {a[15:0], 16'hC0DE};
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_note(input string name, input string msg);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s", name, msg);
   endtask

   // Memory responder: grants after gnt_delay cycles of m_req, answers
   // rsp_delay cycles after the grant; can inject one stray m_rvalid.
   initial begin
      int wait_cnt;
      int rsp_cnt;
      logic [31:0] rsp_addr;
      wait_cnt = 0; rsp_cnt = 0; rsp_addr = '0;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      forever begin
         @(posedge clk); #1;
         m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
         if (rsp_cnt == 1) begin
            m_rvalid = 1'b1; m_rdata = mem_data(rsp_addr); rsp_cnt = 0;
         end else if (rsp_cnt > 1) begin
            rsp_cnt--;
         end
         if (cyc == spur_cyc) begin
            m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
         end
         if (m_req && !rst) begin
            if (wait_cnt >= gnt_delay) begin
               m_gnt = 1'b1; rsp_addr = m_addr; rsp_cnt = rsp_delay; wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a grant or response.
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_if) istall_seen++;
         if (m_req && m_gnt) begin
            if (mq.size() == 0) begin
               fail_note("grant_unexpected", $sformatf("addr %h", m_addr));
            end else begin
               mtx_t e;
               e = mq.pop_front();
               chk("grant_payload", 96'({m_we, m_addr, m_wdata, m_be}),
                   96'({e.we, e.addr, e.wdata, e.be}));
               if (!e.side) begin
                  last_igrant_cyc = cyc;
                  chk("starve_cnt_after_i_grant", 96'(dut.starve_cnt_q), 96'(0));
               end
            end
         end
         if (i_valid) begin
            if (iq.size() == 0) fail_note("i_valid_unexpected", $sformatf("rdata %h", i_rdata));
            else chk("i_rdata", 96'(i_rdata), 96'(iq.pop_front()));
         end
         if (d_valid) begin
            last_dvalid_cyc = cyc;
            if (dq.size() == 0) fail_note("d_valid_unexpected", $sformatf("rdata %h", d_rdata));
            else chk("d_rdata", 96'(d_rdata), 96'(dq.pop_front()));
         end
         if (i_valid && d_valid) fail_note("both_valid", "i_valid and d_valid together");
      end
   end

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
      int n;
      i_req = 1'b1; i_addr = a; iq.push_back(exp);
      n = 0;
      do begin @(negedge clk); n++; end while (!i_valid && n < 80);
      if (!i_valid) fail_note("fetch_timeout", $sformatf("addr %h", a));
      @(posedge clk); #1;
      i_req = 1'b0;
   endtask

   task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] exp, input bit hold);
      int n;
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be; dq.push_back(exp);
      n = 0;
      do begin @(negedge clk); n++; end while (!d_valid && n < 80);
      if (!d_valid) fail_note("d_timeout", $sformatf("addr %h", a));
      @(posedge clk); #1;
      if (!hold) d_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0;
      rst = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

      // Reset state
      @(negedge clk);
      chk("reset_outputs", 96'({m_req, m_we, m_addr, m_wdata, m_be, i_valid, d_valid, stall_if, stall_mem}),
          96'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // 1: lone fetch, 3-cycle latency
      mq.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 4'hF));
      iq.push_back(32'h00A0_0093);
      i_req = 1'b1; i_addr = 32'h100;
      @(negedge clk); chk("s1_cycle0_stall_req_valid", 96'({stall_if, m_req, i_valid}), 96'(3'b100));
      @(negedge clk); chk("s1_cycle1_stall_req_valid", 96'({stall_if, m_req, i_valid}), 96'(3'b110));
      @(negedge clk); chk("s1_cycle2_stall_req_valid", 96'({stall_if, m_req, i_valid}), 96'(3'b001));
      @(posedge clk); #1 i_req = 1'b0;
      @(negedge clk); chk("idle_stalls_low", 96'({stall_if, stall_mem}), 96'(0));
      @(posedge clk); #1;

      // 2: simultaneous fetch and store, D first, then I after one idle cycle
      mq.push_back(mk(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF));
      mq.push_back(mk(1'b0, 1'b0, 32'h104, 32'h0, 4'hF));
      fork
         d_access(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 32'h2000_C0DE, 1'b0);
         fetch(32'h104, 32'h0104_C0DE);
      join
      chk("s2_i_grant_after_d_valid", 96'(last_igrant_cyc), 96'(last_dvalid_cyc + 2));
      @(posedge clk); #1;

      // 3: six back-to-back loads against a pending fetch: D,D,D,D,I,D,D
      for (int k = 0; k < 4; k++) mq.push_back(mk(1'b1, 1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'hF));
      mq.push_back(mk(1'b0, 1'b0, 32'h200, 32'h0, 4'hF));
      for (int k = 4; k < 6; k++) mq.push_back(mk(1'b1, 1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'hF));
      fork
         begin
            for (int k = 0; k < 6; k++)
               d_access(1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'hF,
                        {16'h3000 + 16'(4 * k), 16'hC0DE}, k < 5);
         end
         fetch(32'h200, 32'h0200_C0DE);
      join
      @(negedge clk);
      chk("s3_starve_cnt_final", 96'(dut.starve_cnt_q), 96'(0));
`ifdef ARB_PERF_CNT_EN
      chk("perf_starve", 96'(perf_starve), 96'(1));
      chk("perf_istall", 96'(perf_istall), 96'(istall_seen));
`endif
      @(posedge clk); #1;

      // 4: grant withheld 5 cycles with a stray m_rvalid in ISSUE
      gnt_delay = 5;
      @(posedge clk); #1;
      mq.push_back(mk(1'b1, 1'b0, 32'h4000, 32'h1111_2222, 4'hF));
      dq.push_back(32'h4000_C0DE);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_wdata = 32'h1111_2222; d_be = 4'hF;
      c0 = cyc;
      spur_cyc = c0 + 2;
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("s4_hold_cycle%0d", k),
             96'({m_req, m_we, m_addr, m_wdata, m_be, d_valid, i_valid}),
             96'({1'b1, 1'b0, 32'h4000, 32'h1111_2222, 4'hF, 1'b0, 1'b0}));
      end
      begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (!d_valid && n < 20);
         if (!d_valid) fail_note("s4_timeout", "no d_valid");
         chk("s4_valid_cycle_and_req_low", 96'({cyc - c0, m_req}), 96'({32'(7), 1'b0}));
      end
      @(posedge clk); #1;
      d_req = 1'b0; gnt_delay = 0; spur_cyc = -1;
      rsp_delay = 4;
      @(posedge clk); #1;

      // 5: reset while a load waits for its response
      mq.push_back(mk(1'b1, 1'b0, 32'h5000, 32'h0, 4'hF));
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; d_wdata = 32'h0; d_be = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; d_req = 1'b0;
      #1;
      chk("s5_reset_in_wait", 96'({m_req, d_valid, i_valid, m_we, m_addr, m_wdata, m_be}), 96'(0));
      @(posedge clk); #1;
      rst = 1'b0; rsp_delay = 1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("s5_late_rvalid_ignored", 96'({m_rvalid, d_valid, i_valid}), 96'(3'b100));
      @(posedge clk); #1;
      mq.push_back(mk(1'b1, 1'b0, 32'h5004, 32'h0, 4'hF));
      d_access(1'b0, 32'h5004, 32'h0, 4'hF, 32'h5004_C0DE, 1'b0);
      repeat (3) @(posedge clk);

      @(negedge clk);
      chk("queues_drained", 96'({mq.size(), iq.size(), dq.size()}), 96'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
